// File: rtl/sprite_pkg.sv
// Shared constants for the sprite mover: bounce/wrap mode encoding and position widths.
package sprite_pkg;
   localparam logic MODE_WRAP   = 1'b0;
   localparam logic MODE_BOUNCE = 1'b1;
   localparam int   HPOS_W      = 12;
   localparam int   VPOS_W      = 11;
endpackage

// File: rtl/sprite_mover_axis.sv
// One axis of sprite motion: dead zone, flip-adjusted velocity, wrap/bounce range handling.
module sprite_mover_axis
   import sprite_pkg::*;
#(
   parameter int POS_W = 12,
   parameter int MAX   = 775,
   parameter int INIT  = 387,
   parameter int VW    = 5,
   parameter int DEAD  = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 freeze,
   input  logic                 mode,
   input  logic signed [VW-1:0] vel,
   output logic [POS_W-1:0]     pos,
   output logic                 hit
);
   // Two guard bits keep pos+v exact so both overflow directions are visible.
   localparam int SW = POS_W + 2;
   localparam logic signed [SW-1:0] MAX_S  = SW'(MAX);
   localparam logic signed [VW-1:0] DEAD_S = VW'(DEAD);

   logic                 flip;
   logic                 flip_next;
   logic                 hit_next;
   logic [POS_W-1:0]     pos_next;
   logic signed [VW-1:0] mag;
   logic signed [VW-1:0] vel_dz;
   logic signed [VW-1:0] v_eff;
   logic signed [SW-1:0] sum;

   always_comb begin
      mag       = vel[VW-1] ? -vel : vel;
      vel_dz    = (mag <= DEAD_S) ? '0 : vel;
      v_eff     = flip ? -vel_dz : vel_dz;
      sum       = $signed({2'b00, pos}) + {{(SW-VW){v_eff[VW-1]}}, v_eff};
      pos_next  = POS_W'(sum);
      flip_next = flip;
      hit_next  = 1'b0;
      if (mode == MODE_BOUNCE) begin
         if (sum[SW-1]) begin
            pos_next  = '0;
            flip_next = ~flip;
            hit_next  = 1'b1;
         end else if (sum > MAX_S) begin
            pos_next  = POS_W'(MAX_S);
            flip_next = ~flip;
            hit_next  = 1'b1;
         end
      end else begin
         flip_next = 1'b0;
         if (sum[SW-1]) begin
            pos_next = POS_W'(sum + MAX_S + SW'(1));
            hit_next = 1'b1;
         end else if (sum > MAX_S) begin
            pos_next = POS_W'(sum - MAX_S - SW'(1));
            hit_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pos  <= POS_W'(INIT);
         flip <= 1'b0;
         hit  <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (tick && !freeze) begin
            pos  <= pos_next;
            flip <= flip_next;
            hit  <= hit_next;
         end
      end
   end
endmodule

// File: rtl/tick_divider.sv
// Free-running 0..TICK_DIV-1 counter; tick is registered high for the cycle after the last count.
module tick_divider #(
   parameter int TICK_DIV = 2**20
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;
   logic          last;

   assign last = (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= last;
         count <= last ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/sprite_mover.sv
// Joystick-driven sprite position generator; axes move once per divider tick.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int HOR_FIELD = 800,
   parameter int VER_FIELD = 600,
   parameter int SIZE      = 25,
   parameter int AXIS_W    = 4,
   parameter int DEAD      = 0,
   parameter int TICK_DIV  = 2**20,
   parameter int INIT_H    = (HOR_FIELD - SIZE) / 2,
   parameter int INIT_V    = (VER_FIELD - SIZE) / 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [AXIS_W-1:0] x_axis,
   input  logic [AXIS_W-1:0] y_axis,
   input  logic              mode,
   input  logic              freeze,
   output logic [HPOS_W-1:0] hor_pos,
   output logic [VPOS_W-1:0] ver_pos,
   output logic              tick,
   output logic              hit_h,
   output logic              hit_v
);
   localparam int VW = AXIS_W + 1;
   localparam logic signed [VW-1:0] CENTER    = VW'(2**(AXIS_W-1));
   localparam logic signed [VW-1:0] CENTER_M1 = VW'(2**(AXIS_W-1) - 1);

   logic signed [VW-1:0] vx;
   logic signed [VW-1:0] vy;

   // Screen y grows downward, so the vertical axis is inverted around centre-1.
   assign vx = $signed({1'b0, x_axis}) - CENTER;
   assign vy = CENTER_M1 - $signed({1'b0, y_axis});

   tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   sprite_mover_axis #(
      .POS_W (HPOS_W),
      .MAX   (HOR_FIELD - SIZE),
      .INIT  (INIT_H),
      .VW    (VW),
      .DEAD  (DEAD)
   ) u_axis_h (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .freeze (freeze),
      .mode   (mode),
      .vel    (vx),
      .pos    (hor_pos),
      .hit    (hit_h)
   );

   sprite_mover_axis #(
      .POS_W (VPOS_W),
      .MAX   (VER_FIELD - SIZE),
      .INIT  (INIT_V),
      .VW    (VW),
      .DEAD  (DEAD)
   ) u_axis_v (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .freeze (freeze),
      .mode   (mode),
      .vel    (vy),
      .pos    (ver_pos),
      .hit    (hit_v)
   );
endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter HOR_FIELD, default 800: horizontal field width, pixels.
REQ-002 SHALL have parameter VER_FIELD, default 600: vertical field height, pixels.
REQ-003 SHALL have parameter SIZE, default 25: sprite edge length, pixels.
REQ-004 SHALL have parameter AXIS_W, default 4: joystick axis width; CENTER = 2^(AXIS_W-1).
REQ-005 SHALL have parameter DEAD, default 0: dead-zone magnitude.
REQ-006 SHALL have parameter TICK_DIV, default 2^20: clocks per motion tick, >=2.
REQ-007 SHALL have parameters INIT_H and INIT_V, defaults (HOR_FIELD-SIZE)/2 and (VER_FIELD-SIZE)/2: reset position.
REQ-008 SHALL have port clock, input, 1: single clock, rising edge.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-010 SHALL have ports x_axis and y_axis, input, AXIS_W each: joystick, unsigned.
REQ-011 SHALL have port mode, input, 1: 0 = wrap, 1 = bounce.
REQ-012 SHALL have port freeze, input, 1: hold position.
REQ-013 SHALL have port hor_pos, output, 12: sprite left edge.
REQ-014 SHALL have port ver_pos, output, 11: sprite top edge.
REQ-015 SHALL have port tick, output, 1: one-cycle motion strobe.
REQ-016 SHALL have ports hit_h and hit_v, output, 1 each: one-cycle boundary-event strobes.

Function
REQ-017 Divider SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be registered high for exactly the cycle after the count equals TICK_DIV-1.
REQ-018 Raw velocities SHALL be: vx = x_axis - CENTER; vy = (CENTER-1) - y_axis (signed, AXIS_W+1 bits); |v| <= DEAD SHALL be treated as 0.
REQ-019 Axis inputs SHALL be sampled only in the tick cycle; position, hit flags and flip state SHALL update on the clock edge ending that cycle (latency 1 from tick).
REQ-020 Position ranges SHALL be 0..MAX_H = HOR_FIELD-SIZE and 0..MAX_V = VER_FIELD-SIZE.
REQ-021 Effective velocity SHALL be the raw velocity, negated when that axis's flip bit is 1; next = pos + v_eff in signed arithmetic with no truncation before the range check.
REQ-022 Wrap mode: next < 0 SHALL give next + MAX+1; next > MAX SHALL give next - (MAX+1); flip bits SHALL be cleared at the tick.
REQ-023 Bounce mode: next < 0 SHALL clamp to 0; next > MAX SHALL clamp to MAX; either case SHALL toggle that axis's flip bit.
REQ-024 hit_h and hit_v SHALL pulse for one cycle, coincident with the position update, whenever that axis wrapped or clamped; they SHALL be 0 otherwise.
REQ-025 An axis landing exactly on 0 or MAX SHALL NOT count as a hit.
REQ-026 The axes SHALL be evaluated independently; simultaneous hits on both axes SHALL assert both flags.
REQ-027 freeze=1 at tick SHALL hold position, flip bits and hit flags (hits 0); the divider and tick SHALL continue.
REQ-028 A mode change SHALL take effect at the next tick only.

Reset
REQ-029 reset=1 SHALL asynchronously set: divider 0, tick 0, hit_h/hit_v 0, flip bits 0, hor_pos INIT_H, ver_pos INIT_V.
REQ-030 Reset mid-count SHALL discard the partial tick; the first tick after release SHALL occur TICK_DIV+1 cycles after deassertion.

Structure
REQ-031 Package sprite_pkg SHALL hold MODE_WRAP/MODE_BOUNCE constants and the position-width constants (12, 11).
REQ-032 The divider SHALL be a sub-module tick_divider (parameter TICK_DIV; ports clock, reset, tick).
REQ-033 Per-axis next-position logic SHALL be written once and instanced or generated for both axes.

Verification (bench parameters: HOR_FIELD=40, VER_FIELD=30, SIZE=8, AXIS_W=4, TICK_DIV=4, DEAD=1 -> MAX_H=32, MAX_V=22)
REQ-034 Release reset; hold the axes at 8 and 7 -> tick every 4 cycles; positions stay at 16/11; hit flags 0.
REQ-035 Wrap mode, hor_pos=30, x_axis=11 (vx=+3) -> next tick hor_pos=0 and hit_h=1 for one cycle; then 3.
REQ-036 Bounce mode, hor_pos=31, x_axis=11 -> 32 with hit_h=1; next tick 29 (flipped); hor_pos=3, x_axis=3 (vx=-5 flipped to +5) -> 8.
REQ-037 Bounce mode, both axes at a corner with y_axis=0 (vy=+7), ver_pos=20 -> ver_pos=22; hit_h and hit_v both asserted the same cycle.
REQ-038 x_axis=9 (|vx|=1 <= DEAD) -> hor_pos unchanged; freeze=1 with x_axis=15 -> unchanged while tick keeps toggling.
REQ-039 Assert reset two cycles before a tick while in bounce mode with a flip set -> outputs return to 16/11 immediately and the flip is cleared; first tick occurs 5 cycles after release.
